// File: rtl/a5_keystream_engine.sv
// -----------------------------------------------------------------------------
// a5_keystream_engine
//
// A5/1-style stream cipher engine. A start pulse loads a session key and a
// frame number into three LFSRs, runs the warm-up mixing phase, and then
// produces one DATA_W-bit keystream word ahead of each plaintext word. Each
// accepted plaintext word is XORed with the pending keystream word, and the
// result is held in an output register that uses a valid/ready handshake.
//
// Ports
//   clk        in   1        single clock, rising edge
//   reset      in   1        synchronous, active-high reset
//   start      in   1        pulse; begin keying with key/frame
//   key        in   KEY_W    session key, sampled on start
//   frame      in   FRAME_W  frame number, sampled on start
//   busy       out  1        keying or mixing in progress
//   keyed      out  1        mixing complete, keystream available
//   in_valid   in   1        plaintext word offered
//   in_data    in   DATA_W   plaintext word
//   in_ready   out  1        engine accepts in_data this cycle
//   out_valid  out  1        ciphertext word held
//   out_data   out  DATA_W   in_data XOR keystream word
//   out_ready  in   1        consumer accepts out_data
// -----------------------------------------------------------------------------
module a5_keystream_engine #(
    parameter int KEY_W      = 64,
    parameter int FRAME_W    = 22,
    parameter int MIX_CYCLES = 100,
    parameter int DATA_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               keyed,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        GEN,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [18:0]        r1;
    logic [21:0]        r2;
    logic [22:0]        r3;
    logic [KEY_W-1:0]   key_sh;     // key bits consumed LSB first
    logic [FRAME_W-1:0] frame_sh;   // frame bits consumed LSB first
    logic [31:0]        cnt;        // cycles spent in the current timed state
    logic [DATA_W-1:0]  ks_word;
    logic               accept;

    // Feedback parity of each register.
    logic fb1, fb2, fb3;
    assign fb1 = r1[18] ^ r1[17] ^ r1[16] ^ r1[13];
    assign fb2 = r2[21] ^ r2[20];
    assign fb3 = r3[22] ^ r3[21] ^ r3[20] ^ r3[7];

    // Linear (keying) step: every register steps and absorbs one load bit.
    logic        load_bit;
    logic [18:0] r1_lin;
    logic [21:0] r2_lin;
    logic [22:0] r3_lin;
    assign load_bit = (state == LOAD_KEY) ? key_sh[0] : frame_sh[0];
    assign r1_lin   = {r1[17:0], fb1 ^ load_bit};
    assign r2_lin   = {r2[20:0], fb2 ^ load_bit};
    assign r3_lin   = {r3[21:0], fb3 ^ load_bit};

    // Majority step: only registers whose clock bit agrees with the majority move.
    logic        maj;
    logic [18:0] r1_maj;
    logic [21:0] r2_maj;
    logic [22:0] r3_maj;
    logic        ks_bit;
    assign maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    assign r1_maj = (r1[8]  == maj) ? {r1[17:0], fb1} : r1;
    assign r2_maj = (r2[10] == maj) ? {r2[20:0], fb2} : r2;
    assign r3_maj = (r3[10] == maj) ? {r3[21:0], fb3} : r3;
    assign ks_bit = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: ;
            LOAD_KEY: begin
                busy = 1'b1;
                if (cnt == 32'(KEY_W - 1)) state_next = LOAD_FRAME;
            end
            LOAD_FRAME: begin
                busy = 1'b1;
                if (cnt == 32'(FRAME_W - 1)) state_next = (MIX_CYCLES == 0) ? GEN : MIX;
            end
            MIX: begin
                busy = 1'b1;
                if (cnt == 32'(MIX_CYCLES - 1)) state_next = GEN;
            end
            GEN: begin
                // Only the first keystream word after keying counts as busy.
                busy = ~keyed;
                if (cnt == 32'(DATA_W - 1)) state_next = HOLD;
            end
            HOLD: begin
                in_ready = ~out_valid | out_ready;
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = GEN;
                end
            end
            default: state_next = IDLE;
        endcase
        // A restart wins over any handshake offered in the same cycle.
        if (start) begin
            state_next = LOAD_KEY;
            accept     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            key_sh    <= '0;
            frame_sh  <= '0;
            cnt       <= '0;
            ks_word   <= '0;
            keyed     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (start) begin
            key_sh    <= key;
            frame_sh  <= frame;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            cnt       <= '0;
            keyed     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state_next != state) cnt <= '0;
            else if (state != IDLE && state != HOLD) cnt <= cnt + 32'd1;

            case (state)
                LOAD_KEY, LOAD_FRAME: begin
                    r1 <= r1_lin;
                    r2 <= r2_lin;
                    r3 <= r3_lin;
                    if (state == LOAD_KEY) key_sh   <= key_sh >> 1;
                    else                   frame_sh <= frame_sh >> 1;
                end
                MIX: begin
                    r1 <= r1_maj;
                    r2 <= r2_maj;
                    r3 <= r3_maj;
                end
                GEN: begin
                    r1      <= r1_maj;
                    r2      <= r2_maj;
                    r3      <= r3_maj;
                    // Shift left so the first bit generated ends up in the MSB.
                    ks_word <= (ks_word << 1) | DATA_W'(ks_bit);
                    if (state_next == HOLD) keyed <= 1'b1;
                end
                default: ;
            endcase

            if (accept) begin
                out_data  <= in_data ^ ks_word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a5_keystream_engine.sv
// -----------------------------------------------------------------------------
// tb_a5_keystream_engine
//
// Scoreboard bench for a5_keystream_engine. A reference A5/1 model produces
// keystream words; the driver pushes in_data ^ keystream into a queue on each
// accepted word, and an independent monitor pops and compares on each output
// handshake, also checking that out_data holds still while stalled.
// -----------------------------------------------------------------------------
module tb_a5_keystream_engine;

    localparam int KEY_W      = 64;
    localparam int FRAME_W    = 22;
    localparam int MIX_CYCLES = 100;
    localparam int DATA_W     = 8;
    localparam int LATENCY    = KEY_W + FRAME_W + MIX_CYCLES + DATA_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [KEY_W-1:0]   key;
    logic [FRAME_W-1:0] frame;
    logic               busy;
    logic               keyed;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_ready;

    a5_keystream_engine #(
        .KEY_W(KEY_W), .FRAME_W(FRAME_W), .MIX_CYCLES(MIX_CYCLES), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .frame(frame),
        .busy(busy), .keyed(keyed), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] ks_q[$];   // model keystream words not yet used
    logic [DATA_W-1:0] sb_q[$];   // expected ciphertext words
    bit                mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Registers are held as plain integers; taps are bit masks and feedback is
    // the parity of the tapped bits.
    function automatic bit [63:0] lfsr_step(input bit [63:0] v, input int idx, input bit in_bit);
        bit [63:0] tap;
        int        len;
        bit        fb;
        case (idx)
            0:       begin tap = 64'h0007_2000; len = 19; end
            1:       begin tap = 64'h0030_0000; len = 22; end
            default: begin tap = 64'h0070_0080; len = 23; end
        endcase
        fb = (^(v & tap)) ^ in_bit;
        return ((v << 1) | 64'(fb)) & ((64'd1 << len) - 64'd1);
    endfunction

    task automatic model_fill(input logic [KEY_W-1:0] k, input logic [FRAME_W-1:0] f,
                              input int nwords);
        bit [63:0] r [3];
        int        clk_pos [3];
        int        ones;
        bit        maj;
        bit [63:0] w;
        clk_pos = '{8, 10, 10};
        r       = '{64'd0, 64'd0, 64'd0};
        ks_q.delete();
        for (int i = 0; i < KEY_W; i++)
            for (int j = 0; j < 3; j++) r[j] = lfsr_step(r[j], j, k[i]);
        for (int i = 0; i < FRAME_W; i++)
            for (int j = 0; j < 3; j++) r[j] = lfsr_step(r[j], j, f[i]);
        for (int c = 0; c < MIX_CYCLES + nwords * DATA_W; c++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) ones += int'(r[j][clk_pos[j]]);
            maj = (ones >= 2);
            for (int j = 0; j < 3; j++)
                if (r[j][clk_pos[j]] == maj) r[j] = lfsr_step(r[j], j, 1'b0);
            if (c >= MIX_CYCLES) begin
                w = (w << 1) | 64'(r[0][18] ^ r[1][21] ^ r[2][22]);
                if ((c - MIX_CYCLES) % DATA_W == DATA_W - 1) begin
                    ks_q.push_back(w[DATA_W-1:0]);
                    w = 64'd0;
                end
            end else begin
                w = 64'd0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    bit                stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_prev && out_valid)
                    check("out_data stable under stall", 64'(out_data), 64'(stall_data));
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL ciphertext: unexpected word 0x%0h, scoreboard empty", out_data);
                    end else begin
                        check("ciphertext", 64'(out_data), 64'(sb_q.pop_front()));
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // ---------------- driver helpers (inputs change at posedge + 2) ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [KEY_W-1:0] k, input logic [FRAME_W-1:0] f);
        start = 1'b1;
        key   = k;
        frame = f;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic run_stream(input int nwords);
        int issued = 0;
        int cyc    = 0;
        while (issued < nwords && cyc < 3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data ^ ks_q.pop_front());
                issued++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("words issued", 64'(issued), 64'(nwords));
        drain();
    endtask

    // ---------------- main sequence ----------------
    int                 n;
    logic [KEY_W-1:0]   k_a, k_b;
    logic [FRAME_W-1:0] f_a, f_b;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        key       = '0;
        frame     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset keyed", 64'(keyed), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        tick();

        // All-zero key and frame: registers never leave zero, keystream is 0.
        do_start('0, '0);
        check("busy after start", 64'(busy), 64'd1);
        wait_ready(n);
        check("keying latency zero key", 64'(n), 64'(LATENCY));
        check("keyed after keying", 64'(keyed), 64'd1);
        check("busy after keying", 64'(busy), 64'd0);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("zero key out_valid", 64'(out_valid), 64'd1);
        check("zero key out_data", 64'(out_data), 64'hA5);
        out_ready = 1'b1;
        tick();
        check("out_valid cleared by drain", 64'(out_valid), 64'd0);

        // GSM test vector key/frame, 15 words under random flow control.
        mon_en = 1'b1;
        model_fill(64'h1223456789ABCDEF, 22'h134, 15);
        do_start(64'h1223456789ABCDEF, 22'h134);
        wait_ready(n);
        check("keying latency gsm", 64'(n), 64'(LATENCY));
        run_stream(15);

        // Output stalled for 20 cycles with a second word already offered.
        k_a = {$urandom, $urandom};
        f_a = FRAME_W'($urandom);
        model_fill(k_a, f_a, 2);
        do_start(k_a, f_a);
        wait_ready(n);
        check("keying latency stall run", 64'(n), 64'(LATENCY));
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready before stall", 64'(in_ready), 64'd1);
        sb_q.push_back(in_data ^ ks_q.pop_front());
        tick();
        in_data = DATA_W'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 19) begin
                check("stall out_valid", 64'(out_valid), 64'd1);
                check("stall in_ready in HOLD", 64'(in_ready), 64'd0);
                check("stall keyed", 64'(keyed), 64'd1);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready on release", 64'(in_ready), 64'd1);
        if (in_valid && in_ready) sb_q.push_back(in_data ^ ks_q.pop_front());
        tick();
        in_valid = 1'b0;
        drain();

        // Restart during MIX: result must match a fresh run with the new key.
        k_a = {$urandom, $urandom};
        f_a = FRAME_W'($urandom);
        k_b = {$urandom, $urandom};
        f_b = FRAME_W'($urandom);
        model_fill(k_b, f_b, 10);
        do_start(k_a, f_a);
        for (int i = 0; i < KEY_W + FRAME_W + 10; i++) tick();
        check("busy in MIX", 64'(busy), 64'd1);
        do_start(k_b, f_b);
        check("keyed after restart", 64'(keyed), 64'd0);
        wait_ready(n);
        check("keying latency restart", 64'(n), 64'(LATENCY));
        run_stream(10);

        // start beats a simultaneous handshake in HOLD.
        mon_en    = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        out_ready = 1'b1;
        start     = 1'b1;
        key       = k_a;
        frame     = f_a;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("start priority out_valid", 64'(out_valid), 64'd0);
        check("start priority busy", 64'(busy), 64'd1);

        // Reset while a word is held.
        wait_ready(n);
        check("keying latency before reset", 64'(n), 64'(LATENCY));
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("held word before reset", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        check("reset mid-op out_valid", 64'(out_valid), 64'd0);
        check("reset mid-op keyed", 64'(keyed), 64'd0);
        check("reset mid-op busy", 64'(busy), 64'd0);
        check("reset mid-op out_data", 64'(out_data), 64'd0);
        start = 1'b1;
        tick();
        check("reset overrides start", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle after reset", 64'(busy), 64'd0);
        sb_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
